// File: rtl/song_sequencer.sv
// Walks a song ROM and hands {note, duration} pairs to note_player one at a time.
// Handles song selection, pause, the end-of-song marker and the last-note wrap.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | paused or freshly selected song; waits for play
// FETCH     | rom_addr presented to the synchronous ROM
// WAIT_ROM  | ROM read latency cycle
// DECODE    | rom_data sampled; load the note or detect end-of-song marker
// WAIT_DONE | note playing; waits for done_with_note
// SONG_END  | song finished; waits for a fresh press of play
module song_sequencer #(
    parameter int NOTE_IDX_W = 5,
    parameter int SONG_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic [SONG_W-1:0]            song,
    output logic [SONG_W+NOTE_IDX_W-1:0] rom_addr,
    input  logic [11:0]                  rom_data,
    output logic [5:0]                   note_to_load,
    output logic [5:0]                   duration_to_load,
    output logic                         load_new_note,
    input  logic                         done_with_note,
    output logic                         song_done,
    output logic                         playing
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        DECODE,
        WAIT_DONE,
        SONG_END
    } state_t;

    localparam logic [NOTE_IDX_W-1:0] LAST_IDX = '1;

    state_t                  state;
    logic [NOTE_IDX_W-1:0]   note_idx;
    logic [SONG_W-1:0]       song_q;
    logic                    play_q;

    assign rom_addr = {song_q, note_idx};

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            note_idx         <= '0;
            song_q           <= song;
            play_q           <= 1'b0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
            playing          <= 1'b0;
        end else begin
            play_q        <= play;
            load_new_note <= 1'b0;
            song_done     <= 1'b0;
            // A new song selection abandons whatever is in flight, pulses included.
            if (song != song_q) begin
                song_q   <= song;
                note_idx <= '0;
                state    <= IDLE;
                playing  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (play) begin
                            state   <= FETCH;
                            playing <= 1'b1;
                        end
                    end
                    FETCH:    state <= WAIT_ROM;
                    WAIT_ROM: state <= DECODE;
                    DECODE: begin
                        if (rom_data[5:0] == 6'd0) begin
                            song_done <= 1'b1;
                            note_idx  <= '0;
                            state     <= SONG_END;
                            playing   <= 1'b0;
                        end else begin
                            note_to_load     <= rom_data[11:6];
                            duration_to_load <= rom_data[5:0];
                            load_new_note    <= 1'b1;
                            state            <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (done_with_note) begin
                            if (note_idx == LAST_IDX) begin
                                song_done <= 1'b1;
                                note_idx  <= '0;
                                state     <= SONG_END;
                                playing   <= 1'b0;
                            end else begin
                                note_idx <= note_idx + 1'b1;
                                if (play) begin
                                    state <= FETCH;
                                end else begin
                                    state   <= IDLE;
                                    playing <= 1'b0;
                                end
                            end
                        end
                    end
                    SONG_END: begin
                        // Only a fresh press restarts; a held play must not loop the song.
                        if (play && !play_q) begin
                            state   <= FETCH;
                            playing <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: stimulus pushes expected load/song_done
// events, a negedge monitor pops and compares them as the DUT emits pulses.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic [1:0]  song = 2'd0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        done_with_note = 1'b0;
    logic        song_done;
    logic        playing;

    song_sequencer #(.NOTE_IDX_W(5), .SONG_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .done_with_note   (done_with_note),
        .song_done        (song_done),
        .playing          (playing)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [128];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int addr;
        int note;
        int dur;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  load_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_load(input int addr, input int note, input int dur, input int at);
        ev_t e;
        e.is_done = 1'b0;
        e.addr    = addr;
        e.note    = note;
        e.dur     = dur;
        e.at      = at;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int addr, input int at);
        ev_t e;
        e.is_done = 1'b1;
        e.addr    = addr;
        e.note    = 0;
        e.dur     = 0;
        e.at      = at;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every emitted pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (load_new_note === 1'b1 && song_done === 1'b1) begin
                errors++;
                $display("FAIL pulse_overlap: load_new_note and song_done both high at cycle %0d", cyc);
            end
            if (load_new_note === 1'b1) begin
                load_count++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: addr %0d note %0d dur %0d at cycle %0d",
                             rom_addr, note_to_load, duration_to_load, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (e.is_done || 32'(rom_addr) != e.addr || 32'(note_to_load) != e.note ||
                        32'(duration_to_load) != e.dur || playing !== 1'b1 ||
                        (e.at >= 0 && cyc != e.at)) begin
                        errors++;
                        $display("FAIL load_event: got addr %0d note %0d dur %0d playing %0b cycle %0d; expected done=%0b addr %0d note %0d dur %0d cycle %0d",
                                 rom_addr, note_to_load, duration_to_load, playing, cyc,
                                 e.is_done, e.addr, e.note, e.dur, e.at);
                    end
                end
            end
            if (song_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_song_done: at cycle %0d", cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (!e.is_done || 32'(rom_addr) != e.addr || playing !== 1'b0 ||
                        (e.at >= 0 && cyc != e.at)) begin
                        errors++;
                        $display("FAIL song_done_event: got addr %0d playing %0b cycle %0d; expected done=%0b addr %0d cycle %0d",
                                 rom_addr, playing, cyc, e.is_done, e.addr, e.at);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_event(input bit want_done, output int at);
        bit found;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if ((want_done && song_done === 1'b1) || (!want_done && load_new_note === 1'b1)) begin
                found = 1'b1;
                at = cyc;
            end
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_timeout: no %s within 60 cycles (cycle %0d)",
                     want_done ? "song_done" : "load_new_note", cyc);
        end
    endtask

    task automatic pulse_done();
        done_with_note = 1'b1;
        tick(1);
        done_with_note = 1'b0;
    endtask

    initial begin
        int t;
        int loads_before;
        int n0[8];
        int d0[8];
        n0 = '{20, 33, 7, 9, 11, 13, 15, 17};
        d0 = '{4, 8, 5, 6, 7, 1, 3, 4};

        for (int i = 0; i < 128; i++) rom[i] = 12'h000;
        rom[0]  = {6'd20, 6'd4};
        rom[1]  = {6'd33, 6'd8};
        rom[2]  = {6'd5,  6'd0};
        rom[64] = {6'd40, 6'd9};
        rom[65] = {6'd41, 6'd10};
        for (int i = 0; i < 32; i++) rom[32+i] = {6'(i + 1), 6'd2};

        // Reset with play already high
        song  = 2'd0;
        play  = 1'b1;
        reset = 1'b1;
        tick(3);
        check("rst_load", 32'(load_new_note), 0);
        check("rst_song_done", 32'(song_done), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_note", 32'(note_to_load), 0);
        check("rst_dur", 32'(duration_to_load), 0);
        check("rst_addr", 32'(rom_addr), 0);

        reset = 1'b0;
        push_load(0, 20, 4, cyc + 4);
        wait_event(1'b0, t);

        // Two-cycle done: the second cycle lands in FETCH and must be ignored
        done_with_note = 1'b1;
        push_load(1, 33, 8, t + 4);
        tick(1);
        check("addr_after_done", 32'(rom_addr), 1);
        tick(1);
        done_with_note = 1'b0;
        wait_event(1'b0, t);

        // End-of-song marker at index 2
        push_done(0, t + 4);
        pulse_done();
        wait_event(1'b1, t);
        tick(10);
        check("song_end_playing", 32'(playing), 0);
        check("song_end_addr", 32'(rom_addr), 0);

        rom[2] = {6'd7,  6'd5};
        rom[3] = {6'd9,  6'd6};
        rom[4] = {6'd11, 6'd7};
        rom[5] = {6'd13, 6'd1};
        rom[6] = {6'd15, 6'd3};
        rom[7] = {6'd17, 6'd4};

        // Re-press play restarts at index 0
        play = 1'b0;
        tick(2);
        play = 1'b1;
        push_load(0, 20, 4, cyc + 4);
        wait_event(1'b0, t);
        for (int idx = 1; idx <= 3; idx++) begin
            push_load(idx, n0[idx], d0[idx], t + 4);
            pulse_done();
            wait_event(1'b0, t);
        end

        // Pause mid-note at index 3, then finish the note
        play = 1'b0;
        tick(2);
        pulse_done();
        check("pause_addr", 32'(rom_addr), 4);
        check("pause_playing", 32'(playing), 0);
        tick(6);
        play = 1'b1;
        push_load(4, n0[4], d0[4], cyc + 4);
        wait_event(1'b0, t);
        for (int idx = 5; idx <= 7; idx++) begin
            push_load(idx, n0[idx], d0[idx], t + 4);
            pulse_done();
            wait_event(1'b0, t);
        end

        // Song change at index 7 with a simultaneous done pulse
        song = 2'd2;
        done_with_note = 1'b1;
        tick(1);
        done_with_note = 1'b0;
        check("song_change_addr", 32'(rom_addr), 64);
        check("song_change_playing", 32'(playing), 0);
        push_load(64, 40, 9, cyc + 4);
        wait_event(1'b0, t);

        // Reset asserted while in DECODE
        pulse_done();
        tick(2);
        reset = 1'b1;
        tick(1);
        check("rst_decode_load", 32'(load_new_note), 0);
        check("rst_decode_song_done", 32'(song_done), 0);
        check("rst_decode_playing", 32'(playing), 0);
        check("rst_decode_note", 32'(note_to_load), 0);
        check("rst_decode_dur", 32'(duration_to_load), 0);
        check("rst_decode_addr", 32'(rom_addr), 64);
        tick(2);
        play  = 1'b0;
        reset = 1'b0;

        // Song 1: 32 notes with auto-done, then last-note wrap
        song = 2'd1;
        tick(2);
        check("song1_addr", 32'(rom_addr), 32);
        loads_before = load_count;
        play = 1'b1;
        push_load(32, 1, 2, cyc + 4);
        for (int i = 0; i < 32; i++) begin
            wait_event(1'b0, t);
            if (i < 31) push_load(33 + i, i + 2, 2, t + 4);
            else        push_done(32, t + 1);
            pulse_done();
        end
        tick(8);
        check("song1_load_count", 32'(load_count - loads_before), 32);
        check("song1_wrap_addr", 32'(rom_addr), 32);
        check("song1_playing", 32'(playing), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
